tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit tristate bus between NREQ requesters.
- Each requester drives the bus through its own tristate_32 instance. This block generates the one-hot output enables for those instances.
- Guarantees at most one enable per cycle, a bounded hold time per owner, and idle turnaround cycles between owners so drivers never overlap.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of owner index; equals clog2(NREQ).
- MAX_HOLD, 8, maximum consecutive granted cycles while another requester waits (>=1).
- TURN_CYC, 1, idle cycles inserted between release and next grant (>=1).

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per requester; level-sensitive, held until done.
- oe  output  NREQ  one-hot (or zero) tristate enables, one per tristate_32; registered.
- owner  output  IDW  index of current owner; valid only when busy=1.
- busy  output  1  OR-reduction of oe; registered.
- hold_cnt  output  4  cycles the current owner has held the bus; saturates at 15.

Behaviour:
- Reset: already decided — one clock, reset is asynchronous and active-low (clock, reset_n).
  - While reset_n=0: oe=0, owner=0, busy=0, hold_cnt=0, state=IDLE, priority pointer ptr=0, turn counter=0.
  - Reset mid-grant drops oe immediately (asynchronous).
- States: IDLE, GRANT, TURN.
- Arbitration function: first set bit of req scanning ptr, ptr+1, ..., wrapping modulo NREQ.
- IDLE:
  - If req!=0, go to GRANT next edge with oe=onehot(winner), owner=winner, hold_cnt=1.
  - Latency req->oe is exactly 1 cycle.
  - If req=0, stay in IDLE with oe=0.
- GRANT, each cycle, with O=owner:
  - If req[O]=0: go to TURN. oe=0 next edge, ptr=(O+1) mod NREQ.
  - Else if hold_cnt>=MAX_HOLD and (req & ~onehot(O))!=0: forced release. Go to TURN, oe=0, ptr=(O+1) mod NREQ.
  - Else stay in GRANT, hold_cnt=min(hold_cnt+1,15). Hold beyond MAX_HOLD is allowed only while no other request is pending.
- TURN:
  - oe=0, busy=0 for exactly TURN_CYC cycles.
  - On the last TURN cycle: if req!=0, grant the winner from the updated ptr (enters GRANT, hold_cnt=1); otherwise go to IDLE.
  - The previous owner is eligible again, but only through round-robin order.
- Invariants checked by the bench:
  - popcount(oe)<=1 every cycle.
  - oe never changes directly from one nonzero value to a different nonzero value; at least TURN_CYC zero cycles lie between them.
- Requests dropped before grant: no effect and no memory; the arbiter is purely level-based.
- ptr updates only on release, never in IDLE.
- owner holds its last value when busy=0.

Decomposition:
- Shared package `bus_arb_pkg`:
  - State encoding: IDLE=2'b00, GRANT=2'b01, TURN=2'b10.
  - Default MAX_HOLD and TURN_CYC constants.
  - Width constant for hold_cnt (4).
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: onehot[NREQ], idx[IDW], any.
  - Instantiated once.
- The top holds the FSM, counters and output registers.
- Top-level integration, outside this block: oe[i] drives the oe input of requester i's tristate_32.

Test Plan:
- Reset/idle: reset_n=0 with req=4'b1111 -> oe=0, busy=0. Release reset with req=0 for 5 cycles -> oe stays 0, state IDLE.
- Single request: req=4'b0100 at cycle 0 -> oe=4'b0100, owner=2 at cycle 1.
  - Drop req at cycle 4 -> oe=0 at cycle 5.
  - IDLE from cycle 6; ptr=3.
- Round-robin fairness: after reset, req=4'b1111 held constantly, each requester dropping its own req after 2 granted cycles then reasserting.
  - Grant order 0,1,2,3,0.
  - Exactly 1 zero cycle of oe between each pair of grants.
- Forced release: req[0] held permanently; req[1] asserted at cycle 3 after grant to 0.
  - oe=4'b0001 for exactly 8 cycles (hold_cnt 1..8).
  - Then oe=0 for 1 cycle, then oe=4'b0010.
- Uncontended long hold: only req[3] held for 20 cycles -> oe=4'b1000 continuously; hold_cnt saturates at 15; no turnaround inserted.
- Async reset mid-grant: during GRANT with oe=4'b0010, pulse reset_n low between clock edges.
  - oe=0 before the next edge.
  - After release with req=4'b0010: grant returns 1 cycle later, ptr=0 order.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin tristate bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_t;

    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_TURN_CYC = 1;
    localparam int HOLD_W       = 4;

    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req starting at ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // NOTE: combinational logic uses blocking (=) assignments and gives every
    // output a default first, so no latch is inferred on any path.
    always_comb begin
        int k;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus, with bounded hold
// and idle turnaround cycles so no two drivers are ever enabled together.
module tristate_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   oe,
    output logic [IDW-1:0]    owner,
    output logic              busy,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam int TW = $clog2(TURN_CYC + 1);

    arb_state_t       state;
    logic [IDW-1:0]   ptr;
    logic [TW-1:0]    turn_cnt;

    logic [NREQ-1:0]  pick_oh;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    logic             others_waiting;
    logic             hold_limit;
    logic             release_bus;
    logic [IDW-1:0]   next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // While granted, oe is exactly onehot(owner), so masking with it leaves the competitors.
    assign others_waiting = |(req & ~oe);
    assign hold_limit     = int'(hold_cnt) >= MAX_HOLD;
    assign release_bus    = !req[owner] || (hold_limit && others_waiting);
    assign next_ptr       = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

    // NOTE: every register here is written with non-blocking (<=) assignments
    // so all state updates see the same pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            turn_cnt <= '0;
            oe       <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        oe       <= pick_oh;
                        owner    <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (release_bus) begin
                        state    <= TURN;
                        oe       <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= next_ptr;
                        turn_cnt <= '0;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt == TW'(TURN_CYC - 1)) begin
                        if (pick_any) begin
                            state    <= GRANT;
                            oe       <= pick_oh;
                            owner    <= pick_idx;
                            busy     <= 1'b1;
                            hold_cnt <= HOLD_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: vector table plus hand sequences and bus invariants.
module tb_tristate_bus_arbiter;

    localparam int TURN_CYC = 1;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] hold_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] oe;
        logic [3:0] hold;
    } vec_t;

    vec_t vecs[$];

    tristate_bus_arbiter #(
        .NREQ     (4),
        .IDW      (2),
        .MAX_HOLD (8),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .oe       (oe),
        .owner    (owner),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic void add(input logic [3:0] r, input logic [3:0] o, input logic [3:0] h);
        vec_t v;
        v.req  = r;
        v.oe   = o;
        v.hold = h;
        vecs.push_back(v);
    endfunction

    // Drive req, let one rising edge pass, then compare the registered outputs.
    task automatic step(input logic [3:0] r, input logic [3:0] e_oe, input logic [3:0] e_hold,
                        input string name);
        req = r;
        @(posedge clock);
        #1;
        check({name, " oe"}, oe, e_oe);
        check({name, " busy"}, busy, |e_oe);
        if (e_oe != 4'b0000) begin
            check({name, " owner"}, owner, idx_of(e_oe));
            check({name, " hold"}, hold_cnt, e_hold);
        end
    endtask

    // Bus invariants: never two enables, never a direct owner swap, turnaround gap respected.
    logic [3:0] prev_oe;
    int         zero_run;
    logic       seen_grant;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_oe    = 4'b0000;
            zero_run   = 0;
            seen_grant = 1'b0;
        end else begin
            check("onehot_oe", $countones(oe) <= 1, 1'b1);
            check("no_direct_swap", (prev_oe == 4'b0000) || (oe == 4'b0000) || (oe == prev_oe), 1'b1);
            if (oe != 4'b0000 && prev_oe == 4'b0000 && seen_grant)
                check("turn_gap", zero_run >= TURN_CYC, 1'b1);
            if (oe == 4'b0000) zero_run++;
            else begin
                zero_run   = 0;
                seen_grant = 1'b1;
            end
            prev_oe = oe;
        end
    end

    initial begin
        // Single request, drop, then a ptr=3 probe.
        add(4'b0100, 4'b0100, 4'd1);
        add(4'b0100, 4'b0100, 4'd2);
        add(4'b0100, 4'b0100, 4'd3);
        add(4'b0100, 4'b0100, 4'd4);
        add(4'b0000, 4'b0000, 4'd0);
        add(4'b0000, 4'b0000, 4'd0);
        add(4'b1001, 4'b1000, 4'd1);
        add(4'b0000, 4'b0000, 4'd0);
        add(4'b0000, 4'b0000, 4'd0);
        // Round-robin: everyone requests, each owner drops after two cycles.
        add(4'b1111, 4'b0001, 4'd1);
        add(4'b1111, 4'b0001, 4'd2);
        add(4'b1110, 4'b0000, 4'd0);
        add(4'b1111, 4'b0010, 4'd1);
        add(4'b1111, 4'b0010, 4'd2);
        add(4'b1101, 4'b0000, 4'd0);
        add(4'b1111, 4'b0100, 4'd1);
        add(4'b1111, 4'b0100, 4'd2);
        add(4'b1011, 4'b0000, 4'd0);
        add(4'b1111, 4'b1000, 4'd1);
        add(4'b1111, 4'b1000, 4'd2);
        add(4'b0111, 4'b0000, 4'd0);
        add(4'b1111, 4'b0001, 4'd1);
        add(4'b0000, 4'b0000, 4'd0);
        add(4'b0000, 4'b0000, 4'd0);

        reset_n = 1'b0;
        req     = 4'b1111;
        repeat (2) @(posedge clock);
        #1;
        check("reset oe", oe, 4'b0000);
        check("reset busy", busy, 1'b0);
        check("reset owner", owner, 2'd0);
        check("reset hold", hold_cnt, 4'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++)
            step(4'b0000, 4'b0000, 4'd0, $sformatf("idle%0d", i));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].req, vecs[i].oe, vecs[i].hold, $sformatf("vec%0d", i));

        // Forced release: ptr=1, requester 0 holds on, requester 1 joins at cycle 3.
        step(4'b0001, 4'b0001, 4'd1, "force h1");
        step(4'b0001, 4'b0001, 4'd2, "force h2");
        for (int h = 3; h <= 8; h++)
            step(4'b0011, 4'b0001, 4'(h), $sformatf("force h%0d", h));
        step(4'b0011, 4'b0000, 4'd0, "force turn");
        step(4'b0011, 4'b0010, 4'd1, "force next");
        step(4'b0000, 4'b0000, 4'd0, "force rel");
        step(4'b0000, 4'b0000, 4'd0, "force idle");

        // Uncontended long hold saturates the counter with no turnaround.
        for (int i = 1; i <= 20; i++)
            step(4'b1000, 4'b1000, (i > 15) ? 4'd15 : 4'(i), $sformatf("long%0d", i));
        step(4'b0000, 4'b0000, 4'd0, "long rel");
        step(4'b0000, 4'b0000, 4'd0, "long idle");

        // Leave ptr at 3 so a reset back to ptr=0 is observable.
        step(4'b0100, 4'b0100, 4'd1, "pre g2");
        step(4'b0000, 4'b0000, 4'd0, "pre rel");
        step(4'b0000, 4'b0000, 4'd0, "pre idle");
        step(4'b0010, 4'b0010, 4'd1, "arst g1");
        step(4'b0010, 4'b0010, 4'd2, "arst g2");

        #1 reset_n = 1'b0;
        #1;
        check("arst oe", oe, 4'b0000);
        check("arst busy", busy, 1'b0);
        check("arst hold", hold_cnt, 4'd0);
        check("arst owner", owner, 2'd0);
        #1 reset_n = 1'b1;

        // From ptr=0 requester 1 outranks 3; a stale ptr=3 would pick 3.
        step(4'b1010, 4'b0010, 4'd1, "arst regrant");
        step(4'b0000, 4'b0000, 4'd0, "arst rel");
        step(4'b0000, 4'b0000, 4'd0, "arst idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
